npc_unit: RTL and testbench

Parametrised fetch-stage next-PC unit for the 5-stage MIPS pipeline with branch delay slot. It owns the PC register and resolves all D-stage control transfers. Branch conditions are evaluated internally from forwarded rs/rt values. Exception redirect, `eret` return, and stall hold are handled in-block. It flags delay-slot fetches and fetch address errors for the CP0 exception path.

---
 rtl/npc_unit.sv | 123 ++++++++++++
 tb/tb_npc_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/npc_unit.sv
// npc_unit: owns the fetch PC, resolves D-stage branches/jumps/eret,
// handles exception redirect and stall hold, and flags delay slots and
// fetch address errors for the CP0 exception path.
module npc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter int unsigned IM_WORDS   = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_req,
  input  logic [31:0] epc,
  input  logic        d_valid,
  input  logic [31:0] d_pc,
  input  logic [2:0]  d_br_op,
  input  logic        d_j,
  input  logic        d_jr,
  input  logic        d_eret,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_imm26,
  input  logic [31:0] d_rs,
  input  logic [31:0] d_rt,
  output logic [31:0] f_pc,
  output logic        f_bd,
  output logic        f_adel,
  output logic        f_flush,
  output logic        d_taken,
  output logic [31:0] link_addr
);

  // One past the last legal fetch byte; 33 bits so a range ending at 4 GiB
  // does not wrap to zero.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_RSVD = 3'd7
  } br_op_t;

  logic [31:0] pc4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        br_cond;
  logic        is_branch;
  logic        is_xfer;
  logic        eret_v;
  logic [31:0] pc_next;
  logic        bd_next;

  assign pc4       = d_pc + 32'd4;
  assign br_target = pc4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
  assign j_target  = {pc4[31:28], d_imm26, 2'b00};
  assign link_addr = d_pc + 32'd8;

  // Evaluate the branch condition with signed compares on forwarded values.
  always_comb begin
    br_cond   = 1'b0;
    is_branch = 1'b0;
    case (br_op_t'(d_br_op))
      BR_BEQ:  begin is_branch = 1'b1; br_cond = (d_rs == d_rt); end
      BR_BNE:  begin is_branch = 1'b1; br_cond = (d_rs != d_rt); end
      BR_BLEZ: begin is_branch = 1'b1; br_cond = ($signed(d_rs) <= 0); end
      BR_BGTZ: begin is_branch = 1'b1; br_cond = ($signed(d_rs) > 0); end
      BR_BLTZ: begin is_branch = 1'b1; br_cond = ($signed(d_rs) < 0); end
      BR_BGEZ: begin is_branch = 1'b1; br_cond = ($signed(d_rs) >= 0); end
      default: begin is_branch = 1'b0; br_cond = 1'b0; end
    endcase
  end

  assign d_taken = d_valid & is_branch & br_cond;
  assign is_xfer = d_valid & (is_branch | d_j | d_jr);
  assign eret_v  = d_valid & d_eret;
  assign f_flush = eret_v & ~stall & ~exc_req;
  assign f_adel  = (f_pc[1:0] != 2'b00) | (f_pc < IM_BASE) |
                   ({1'b0, f_pc} >= IM_END);

  // Pick the next fetch PC and delay-slot flag in priority order.
  always_comb begin
    pc_next = f_pc + 32'd4;
    bd_next = 1'b0;
    if (exc_req) begin
      pc_next = HANDLER_PC;
      bd_next = 1'b0;
    end else if (stall) begin
      pc_next = f_pc;
      bd_next = f_bd;
    end else if (eret_v) begin
      pc_next = epc;
      bd_next = 1'b0;
    end else begin
      bd_next = is_xfer;
      if (d_taken) begin
        pc_next = br_target;
      end else if (d_valid & d_jr) begin
        pc_next = d_rs;
      end else if (d_valid & d_j) begin
        pc_next = j_target;
      end else begin
        pc_next = f_pc + 32'd4;
      end
    end
  end

  // PC and delay-slot registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc <= RESET_PC;
      f_bd <= 1'b0;
    end else begin
      f_pc <= pc_next;
      f_bd <= bd_next;
    end
  end

endmodule

// File: tb/tb_npc_unit.sv
// tb_npc_unit: scoreboard bench for npc_unit; expected f_pc/f_bd values are
// queued when stimulus is applied and compared after the clock edge.
module tb_npc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        exc_req;
  logic [31:0] epc;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [2:0]  d_br_op;
  logic        d_j;
  logic        d_jr;
  logic        d_eret;
  logic [15:0] d_imm16;
  logic [25:0] d_imm26;
  logic [31:0] d_rs;
  logic [31:0] d_rt;
  logic [31:0] f_pc;
  logic        f_bd;
  logic        f_adel;
  logic        f_flush;
  logic        d_taken;
  logic [31:0] link_addr;

  int errors = 0;
  int checks = 0;

  logic [31:0] expPcQ[$];
  logic        expBdQ[$];
  string       tagQ[$];

  npc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .exc_req(exc_req), .epc(epc),
    .d_valid(d_valid), .d_pc(d_pc), .d_br_op(d_br_op), .d_j(d_j),
    .d_jr(d_jr), .d_eret(d_eret), .d_imm16(d_imm16), .d_imm26(d_imm26),
    .d_rs(d_rs), .d_rt(d_rt), .f_pc(f_pc), .f_bd(f_bd), .f_adel(f_adel),
    .f_flush(f_flush), .d_taken(d_taken), .link_addr(link_addr)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
    end
  endtask

  // Queue the expected post-edge state, clock once, then pop and compare.
  task automatic applyStimulus(input string tag, input logic [31:0] expPc,
                               input logic expBd);
    expPcQ.push_back(expPc);
    expBdQ.push_back(expBd);
    tagQ.push_back(tag);
    @(posedge clk);
    #1;
    begin
      string t;
      t = tagQ.pop_front();
      checkOutput({t, ".f_pc"}, f_pc, expPcQ.pop_front());
      checkOutput({t, ".f_bd"}, {31'd0, f_bd}, {31'd0, expBdQ.pop_front()});
    end
  endtask

  task automatic clearD();
    stall = 0; exc_req = 0; epc = 0; d_valid = 0; d_pc = 0; d_br_op = 0;
    d_j = 0; d_jr = 0; d_eret = 0; d_imm16 = 0; d_imm26 = 0; d_rs = 0; d_rt = 0;
  endtask

  task automatic setJr(input logic [31:0] target);
    clearD();
    d_valid = 1; d_pc = 32'h3008; d_jr = 1; d_rs = target;
  endtask

  task automatic setBranch(input logic [2:0] op, input logic [31:0] pc,
                           input logic [15:0] imm, input logic [31:0] rs,
                           input logic [31:0] rt);
    clearD();
    d_valid = 1; d_br_op = op; d_pc = pc; d_imm16 = imm; d_rs = rs; d_rt = rt;
  endtask

  // Main stimulus sequence following the test plan plus boundary cases.
  initial begin
    clearD();
    reset = 1;
    #2;
    applyStimulus("reset1", 32'h3000, 0);
    applyStimulus("reset2", 32'h3000, 0);
    checkOutput("reset.adel", {31'd0, f_adel}, 32'd0);
    reset = 0;
    applyStimulus("seq1", 32'h3004, 0);
    applyStimulus("seq2", 32'h3008, 0);

    // beq taken / not taken with F sitting at 0x3014
    setJr(32'h3014);
    applyStimulus("jr3014a", 32'h3014, 1);
    setBranch(3'd1, 32'h3010, 16'hFFFC, 32'd5, 32'd5);
    #1 checkOutput("beq.taken", {31'd0, d_taken}, 32'd1);
    applyStimulus("beqTaken", 32'h3004, 1);
    setJr(32'h3014);
    applyStimulus("jr3014b", 32'h3014, 1);
    setBranch(3'd1, 32'h3010, 16'hFFFC, 32'd5, 32'd6);
    #1 checkOutput("beq.nt", {31'd0, d_taken}, 32'd0);
    applyStimulus("beqNotTaken", 32'h3018, 1);

    // Signed compares on the most-negative value
    setBranch(3'd4, 32'h3010, 16'hFFFC, 32'h8000_0000, 32'd0);
    #1 checkOutput("bgtz.nt", {31'd0, d_taken}, 32'd0);
    applyStimulus("bgtzNt", 32'h301C, 1);
    setBranch(3'd5, 32'h3010, 16'hFFFC, 32'h8000_0000, 32'd0);
    #1 checkOutput("bltz.taken", {31'd0, d_taken}, 32'd1);
    applyStimulus("bltzTaken", 32'h3004, 1);

    // Zero and minus-one boundaries, bne and reserved op
    setBranch(3'd3, 32'h3010, 16'h0, 32'd0, 32'd0);
    #1 checkOutput("blez.zero", {31'd0, d_taken}, 32'd1);
    setBranch(3'd4, 32'h3010, 16'h0, 32'd0, 32'd0);
    #1 checkOutput("bgtz.zero", {31'd0, d_taken}, 32'd0);
    setBranch(3'd6, 32'h3010, 16'h0, 32'hFFFF_FFFF, 32'd0);
    #1 checkOutput("bgez.m1", {31'd0, d_taken}, 32'd0);
    setBranch(3'd2, 32'h3010, 16'h0, 32'd1, 32'd2);
    #1 checkOutput("bne.taken", {31'd0, d_taken}, 32'd1);
    setBranch(3'd7, 32'h3010, 16'h0, 32'd1, 32'd1);
    #1 checkOutput("rsvd.none", {31'd0, d_taken}, 32'd0);

    // Bubble in D: a would-be taken beq is ignored; F is at 0x3004
    setBranch(3'd1, 32'h3010, 16'hFFFC, 32'd5, 32'd5);
    d_valid = 0;
    #1 checkOutput("bubble.taken", {31'd0, d_taken}, 32'd0);
    applyStimulus("bubble", 32'h3008, 0);

    // jal and jr to a misaligned address
    clearD();
    d_valid = 1; d_pc = 32'h3020; d_j = 1; d_imm26 = 26'h0000C40;
    #1 checkOutput("jal.link", link_addr, 32'h3028);
    applyStimulus("jal", 32'h3100, 1);
    setJr(32'h3001);
    applyStimulus("jrMis", 32'h3001, 1);
    checkOutput("jrMis.adel", {31'd0, f_adel}, 32'd1);

    // Branch held by stall for 3 cycles, then released
    clearD();
    applyStimulus("plain", 32'h3005, 0);
    setBranch(3'd1, 32'h3010, 16'h0004, 32'd7, 32'd7);
    stall = 1;
    applyStimulus("stall1", 32'h3005, 0);
    applyStimulus("stall2", 32'h3005, 0);
    applyStimulus("stall3", 32'h3005, 0);
    stall = 0;
    applyStimulus("stallRel", 32'h3024, 1);

    // Stall holds f_bd=1, then exception during stall wins
    stall = 1;
    applyStimulus("stallBd", 32'h3024, 1);
    exc_req = 1;
    #1 checkOutput("exc.flush", {31'd0, f_flush}, 32'd0);
    applyStimulus("excStall", 32'h4180, 0);

    // eret after a transfer clears f_bd and flushes
    setJr(32'h3000);
    applyStimulus("jr3000", 32'h3000, 1);
    clearD();
    d_valid = 1; d_eret = 1; epc = 32'h3040; d_pc = 32'h3004;
    #1 checkOutput("eret.flush", {31'd0, f_flush}, 32'd1);
    applyStimulus("eret", 32'h3040, 0);
    stall = 1;
    #1 checkOutput("eretStall.flush", {31'd0, f_flush}, 32'd0);
    stall = 0;
    exc_req = 1;
    #1 checkOutput("eretExc.flush", {31'd0, f_flush}, 32'd0);
    applyStimulus("eretExc", 32'h4180, 0);

    // Upper edge of instruction memory and PC wrap
    setJr(32'h6FFC);
    applyStimulus("jrTop", 32'h6FFC, 1);
    checkOutput("top.adel", {31'd0, f_adel}, 32'd0);
    clearD();
    applyStimulus("pastTop", 32'h7000, 0);
    checkOutput("pastTop.adel", {31'd0, f_adel}, 32'd1);
    setJr(32'hFFFF_FFFC);
    applyStimulus("jrWrap", 32'hFFFF_FFFC, 1);
    clearD();
    applyStimulus("wrap", 32'h0000_0000, 0);
    checkOutput("wrap.adel", {31'd0, f_adel}, 32'd1);

    // Reset during a stalled branch wins outright
    setBranch(3'd1, 32'h3010, 16'h0004, 32'd1, 32'd1);
    stall = 1;
    reset = 1;
    applyStimulus("resetStall", 32'h3000, 0);
    reset = 0;
    clearD();
    applyStimulus("postReset", 32'h3004, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
